bt_uart_rx: RTL and testbench

//  Bluetooth-module UART receiver on the CLOCK_10 domain. Sits upstream of the BT pattern decoder.

---
 rtl/bt_uart_rx.sv | 149 ++++++++++++++
 tb/tb_bt_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the BT module line: two-flop synchroniser, bit-sampling FSM and a small
// show-ahead byte FIFO with a valid/ready pop, plus sample-strobe, framing and overrun status.
module bt_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLOCK_10,
  input  logic       reset,
  input  logic       BT_Rx,
  input  logic       rx_ready,
  input  logic       ovr_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       bit_tick,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e        state;
  logic          sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;

  // Both flops reset to the idle (high) line level.
  always_ff @(posedge CLOCK_10 or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= BT_Rx;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge CLOCK_10 or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      bit_tick  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bit_tick  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            state <= StStart;
            cnt   <= '0;
          end
        end
        StStart: begin
          if (cnt == HALF_CNT) begin
            bit_tick <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            state    <= rx_s ? StIdle : StData;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StData: begin
          if (cnt == FULL_CNT) begin
            bit_tick <= 1'b1;
            sh       <= {rx_s, sh[7:1]};
            cnt      <= '0;
            idx      <= idx + 3'd1;
            if (idx == 3'd7) state <= StStop;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StStop: begin
          if (cnt == FULL_CNT) begin
            bit_tick <= 1'b1;
            cnt      <= '0;
            if (rx_s) begin
              state <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state     <= StBreak;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StBreak: begin
          // Hold off until the line returns high so a stuck-low line cannot re-trigger.
          if (rx_s) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign push     = (state == StStop) && (cnt == FULL_CNT) && rx_s;
  assign full     = (count == DEPTH_CNT);
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign wr_en    = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign rx_busy  = (state != StIdle);

  always_ff @(posedge CLOCK_10) begin
    if (wr_en) mem[wr_ptr] <= sh;
  end

  always_ff @(posedge CLOCK_10 or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
      // A dropped byte wins over a same-cycle clear.
      if (push && !wr_en) overrun <= 1'b1;
      else if (ovr_clr)   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Scoreboard bench for bt_uart_rx: frames are driven on the line, expected bytes queued,
// and every FIFO pop is compared against the queue head.
module tb_bt_uart_rx;

  // Shortened bit period so the whole run stays small.
  localparam int unsigned CPB = 100;
  // Cycles from a start edge to the stop-bit sample edge.
  localparam int unsigned STOP_EDGE = CPB / 2 + 3 + 9 * CPB;

  logic       clk;
  logic       rst;
  logic       bt_rx;
  logic       rx_ready;
  logic       ovr_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       bit_tick;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;
  int fe_cnt = 0;
  int tick_dbl = 0;
  int fe_dbl = 0;
  int rise_bad = 0;
  logic prev_tick = 1'b0;
  logic prev_fe = 1'b0;
  logic prev_valid = 1'b0;

  bt_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLOCK_10 (clk),
    .reset    (rst),
    .BT_Rx    (bt_rx),
    .rx_ready (rx_ready),
    .ovr_clr  (ovr_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .bit_tick (bit_tick),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedges; sample shortly after, well clear of either edge.
  always @(negedge clk) begin
    #10;
    if (bit_tick) tick_cnt++;
    if (frame_err) fe_cnt++;
    if (bit_tick && prev_tick) tick_dbl++;
    if (frame_err && prev_fe) fe_dbl++;
    if (rx_valid && !prev_valid && !bit_tick) rise_bad++;
    prev_tick  = bit_tick;
    prev_fe    = frame_err;
    prev_valid = rx_valid;
    if (rx_valid && rx_ready) begin
      check_eq("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("rx_data_pop", rx_data, exp_q.pop_front());
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    bt_rx = 1'b0;
    wait_cycles(CPB - 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bt_rx = b[i];
      wait_cycles(CPB - 1);
    end
    @(negedge clk);
    bt_rx = stop;
    wait_cycles(CPB - 1);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    rx_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    wait_cycles(2);
    check_eq(tag, exp_q.size(), 0);
    check_eq({tag, "_empty"}, rx_valid, 0);
  endtask

  initial begin
    rst      = 1'b1;
    bt_rx    = 1'b1;
    rx_ready = 1'b0;
    ovr_clr  = 1'b0;
    wait_cycles(5);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_tick", bit_tick, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_busy", rx_busy, 0);
    rst = 1'b0;
    wait_cycles(5);

    // Two back-to-back bytes, held until popped.
    tick_cnt = 0;
    exp_q.push_back(8'h31);
    send_byte(8'h31, 1'b1);
    wait_cycles(5);
    check_eq("t1_valid", rx_valid, 1);
    check_eq("t1_head", rx_data, 8'h31);
    check_eq("t1_ticks1", tick_cnt, 10);
    exp_q.push_back(8'h32);
    send_byte(8'h32, 1'b1);
    wait_cycles(5);
    check_eq("t1_ticks2", tick_cnt, 20);
    drain("t1_drain");

    // Short low glitch: only the start-check tick, then back to idle.
    tick_cnt = 0;
    @(negedge clk);
    bt_rx = 1'b0;
    wait_cycles(CPB * 3 / 10);
    bt_rx = 1'b1;
    wait_cycles(2 * CPB);
    check_eq("t2_ticks", tick_cnt, 1);
    check_eq("t2_valid", rx_valid, 0);
    check_eq("t2_data", rx_data, 0);
    check_eq("t2_busy", rx_busy, 0);

    // Framing error with the line held low, then a clean byte.
    tick_cnt = 0;
    fe_cnt = 0;
    send_byte(8'hA5, 1'b0);
    wait_cycles(3 * CPB);
    check_eq("t3_ferr", fe_cnt, 1);
    check_eq("t3_valid", rx_valid, 0);
    check_eq("t3_break_busy", rx_busy, 1);
    check_eq("t3_ticks", tick_cnt, 10);
    @(negedge clk);
    bt_rx = 1'b1;
    wait_cycles(5);
    check_eq("t3_idle", rx_busy, 0);
    check_eq("t3_ticks_after", tick_cnt, 10);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    wait_cycles(10);
    check_eq("t3_good", exp_q.size(), 0);

    // Fill the FIFO, then overflow it.
    @(negedge clk);
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
      wait_cycles(3);
      if (i == 4) check_eq("t4_no_ovr", overrun, 0);
    end
    check_eq("t4_ovr", overrun, 1);
    check_eq("t4_head", rx_data, 8'h01);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    wait_cycles(1);
    check_eq("t4_ovr_clr", overrun, 0);

    // Full FIFO with a pop landing on the same edge as the push.
    exp_q.push_back(8'h06);
    fork
      send_byte(8'h06, 1'b1);
      begin
        @(negedge clk);
        wait_cycles(STOP_EDGE - 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    wait_cycles(3);
    check_eq("t5_no_ovr", overrun, 0);
    check_eq("t5_sb_depth", exp_q.size(), 4);
    drain("t5_drain");

    // Reset part-way through a frame with a byte buffered.
    @(negedge clk);
    rx_ready = 1'b0;
    send_byte(8'h77, 1'b1);
    wait_cycles(5);
    check_eq("t6_prefill", rx_valid, 1);
    @(negedge clk);
    bt_rx = 1'b0;
    wait_cycles(CPB);
    bt_rx = 1'b1;
    wait_cycles(3 * CPB);
    check_eq("t6_busy_pre", rx_busy, 1);
    rst = 1'b1;
    #1;
    check_eq("t6_valid", rx_valid, 0);
    check_eq("t6_data", rx_data, 0);
    check_eq("t6_tick", bit_tick, 0);
    check_eq("t6_ferr", frame_err, 0);
    check_eq("t6_ovr", overrun, 0);
    check_eq("t6_busy", rx_busy, 0);
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(5);
    exp_q.push_back(8'hC3);
    rx_ready = 1'b1;
    send_byte(8'hC3, 1'b1);
    drain("t6_drain");

    check_eq("tick_width", tick_dbl, 0);
    check_eq("ferr_width", fe_dbl, 0);
    check_eq("valid_rise_align", rise_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
